core_bus_arbiter: RTL
=====================

CORE_BUS_ARBITER -- requirements
Module: core_bus_arbiter

Interface
REQ-001 SHALL have parameter N_MASTER, default 2, meaning number of requesting naive_bus masters (2..4); index 0 = instruction fetch, 1 = data access.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port masters[N_MASTER]  naive_bus.slave  array  upstream requesters (rd_req, rd_be[3:0], rd_addr[31:0], rd_gnt, rd_data[31:0], wr_req, wr_be[3:0], wr_addr[31:0], wr_data[31:0], wr_gnt).
REQ-005 SHALL have port slave  naive_bus.master  1  the single shared downstream memory/peripheral port.
REQ-006 SHALL have port o_rr_ptr  output  2  current round-robin priority pointer, for debug/verification.

Function
REQ-007 SHALL treat master i as requesting in a cycle when rd_req|wr_req is high.
REQ-008 SHALL combinationally select one requester per cycle: the first requesting index at or after o_rr_ptr, wrapping modulo N_MASTER.
REQ-009 SHALL forward only the selected master's rd_*/wr_* fields to slave; with no requester, slave rd_req=wr_req=0 and all addr/be/data=0.
REQ-010 SHALL drive masters[i].rd_gnt = slave.rd_gnt & (i==sel) and masters[i].wr_gnt = slave.wr_gnt & (i==sel); non-selected masters see gnt=0 in the same cycle (zero added grant latency).
REQ-011 SHALL advance o_rr_ptr to (sel+1) mod N_MASTER at a clock edge only when the selected master received rd_gnt or wr_gnt; otherwise o_rr_ptr holds.
REQ-012 SHALL register rd_owner (index) and rd_owner_vld at each edge: rd_owner_vld = slave.rd_req & slave.rd_gnt, rd_owner = sel.
REQ-013 SHALL, when rd_owner_vld=1, route slave.rd_data to masters[rd_owner].rd_data in the cycle after grant; all other masters' rd_data = 0, and all rd_data = 0 when rd_owner_vld=0.
REQ-014 SHALL route read data correctly when a new grant to a different master occurs in the same cycle as returning data (back-to-back pipelining, one outstanding read per cycle).
REQ-015 SHALL forward a master's simultaneous rd_req and wr_req together when that master is selected; slave gnts apply independently.
REQ-016 SHALL keep the selection stable while the slave withholds gnt and the selected master keeps requesting, unless a higher-priority request per REQ-008 appears (no lock; re-evaluated each cycle).
REQ-017 SHALL, for N_MASTER not a power of two, wrap pointer from N_MASTER-1 to 0 and never hold a value >= N_MASTER.
REQ-018 SHALL be purely combinational from masters to slave request path; only o_rr_ptr, rd_owner, rd_owner_vld are state.

Reset
REQ-019 SHALL on rst_n low asynchronously set o_rr_ptr=0, rd_owner=0, rd_owner_vld=0.
REQ-020 SHALL during and immediately after reset drive all masters' rd_data=0, consistent with REQ-013; gnt outputs follow REQ-010 combinationally.
REQ-021 SHALL, if reset asserts with a read granted in the previous cycle, discard that return (rd_owner_vld=0 forces rd_data=0).

Structure
REQ-022 SHALL place N_MASTER limits and master index constants (MST_IFETCH=0, MST_DATA=1) in a shared core package.
REQ-023 SHALL implement selection as one sub-module rr_pick (request vector + pointer -> one-hot grant + index), instantiated once.

Verification
REQ-024 Only master0 reads 0x0000_0100, slave gnt=1 -> master0 rd_gnt same cycle, next cycle master0 rd_data=slave data 0x1234_5678, master1 rd_data=0, ptr 0->1.
REQ-025 Both request reads every cycle, slave always grants, ptr=0 -> grants alternate 0,1,0,1; each rd_data lands on the correct master one cycle later.
REQ-026 Both request, slave gnt=0 for 3 cycles -> only sel master sees forwarded addr, no gnt to anyone, ptr holds at 0; gnt on cycle 4 -> master0 granted, ptr=1.
REQ-027 Master1 write 0x0000_2000 data 0xDEAD_BEEF be=4'hF while master0 idle -> slave sees exact write fields, master1 wr_gnt=1, rd_data of all masters=0 next cycle.
REQ-028 rst_n asserted in the cycle after a master0 read grant -> master0 rd_data=0, ptr=0 immediately, no spurious data after release.
REQ-029 N_MASTER=3, masters 0 and 2 requesting, ptr=1 -> master2 granted, ptr wraps to 0, next grant master0.

Source files
------------

// File: rtl/core_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter_pkg
//   Shared definitions for the core bus arbiter slice:
//     - supported master-count limits
//     - well-known master indices (instruction fetch, data access)
//     - master index type sized for the 2-bit round-robin pointer
//     - packed bundle of the request-side naive_bus fields, used to mux
//       the selected master onto the shared downstream port
//     - wrap_inc(): modulo-n increment of a master index
// -----------------------------------------------------------------------------
package core_bus_arbiter_pkg;

  localparam int unsigned N_MASTER_MIN = 2;
  localparam int unsigned N_MASTER_MAX = 4;

  localparam int unsigned MST_IFETCH = 0;
  localparam int unsigned MST_DATA   = 1;

  // Wide enough for N_MASTER_MAX masters; matches the o_rr_ptr port width.
  typedef logic [1:0] mst_idx_t;

  // Everything a master drives towards the downstream port.
  typedef struct packed {
    logic        rd_req;
    logic [3:0]  rd_be;
    logic [31:0] rd_addr;
    logic        wr_req;
    logic [3:0]  wr_be;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
  } bus_req_t;

  // Increment idx, wrapping to zero at n (n need not be a power of two).
  function automatic mst_idx_t wrap_inc(input mst_idx_t idx, input int unsigned n);
    if ((32'(idx) + 32'd1) >= n) begin
      return '0;
    end
    return idx + 2'd1;
  endfunction

endpackage : core_bus_arbiter_pkg

// File: rtl/core_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// naive_bus
//   Simple split read/write memory bus with same-cycle grant and read data
//   returned one cycle after the read grant.
//
//   Signals
//     rd_req, rd_be[3:0], rd_addr[31:0]          read request   (master -> slave)
//     rd_gnt                                     read grant     (slave  -> master)
//     rd_data[31:0]                              read data, cycle after rd_gnt
//     wr_req, wr_be[3:0], wr_addr[31:0],
//     wr_data[31:0]                              write request  (master -> slave)
//     wr_gnt                                     write grant    (slave  -> master)
//
//   Modports
//     master : the requesting side
//     slave  : the responding side
// -----------------------------------------------------------------------------
interface naive_bus;
  import core_bus_arbiter_pkg::*;

  logic        rd_req;
  logic [3:0]  rd_be;
  logic [31:0] rd_addr;
  logic        rd_gnt;
  logic [31:0] rd_data;

  logic        wr_req;
  logic [3:0]  wr_be;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_gnt;

  modport master (
    output rd_req, rd_be, rd_addr,
    input  rd_gnt, rd_data,
    output wr_req, wr_be, wr_addr, wr_data,
    input  wr_gnt
  );

  modport slave (
    input  rd_req, rd_be, rd_addr,
    output rd_gnt, rd_data,
    input  wr_req, wr_be, wr_addr, wr_data,
    output wr_gnt
  );

endinterface : naive_bus

// File: rtl/core_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: selects the first asserted request at
//   or after ptr, wrapping modulo N.
//
//   Parameters
//     N       number of requesters (2..4)
//   Ports
//     req     [N-1:0] request vector
//     ptr     current priority pointer (assumed < N)
//     gnt_oh  [N-1:0] one-hot selection (all zero when nothing requests)
//     idx     index of the selected requester (0 when nothing requests)
//     vld     high when some requester is selected
// -----------------------------------------------------------------------------
module rr_pick
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  mst_idx_t     ptr,
  output logic [N-1:0] gnt_oh,
  output mst_idx_t     idx,
  output logic         vld
);

  // Rotate the request vector so bit 0 is the requester at ptr; doubling the
  // vector makes the wrap at N free of any modulo arithmetic.
  logic [2*N-1:0] req2;
  logic [N-1:0]   rot;
  mst_idx_t       off;
  logic [2:0]     sum;

  assign req2 = {req, req};
  assign rot  = N'(req2 >> ptr);

  always_comb begin
    off = '0;
    vld = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!vld && rot[k]) begin
        vld = 1'b1;
        off = mst_idx_t'(k);
      end
    end
  end

  // Undo the rotation: idx = (ptr + off) mod N, with ptr, off < N.
  always_comb begin
    sum = {1'b0, ptr} + {1'b0, off};
    idx = '0;
    if (vld) begin
      idx = (sum >= 3'(N)) ? mst_idx_t'(sum - 3'(N)) : sum[1:0];
    end
  end

  always_comb begin
    gnt_oh = '0;
    for (int unsigned j = 0; j < N; j++) begin
      gnt_oh[j] = vld && (idx == mst_idx_t'(j));
    end
  end

endmodule : rr_pick

// File: rtl/core_bus_arbiter.sv
// -----------------------------------------------------------------------------
// core_bus_arbiter
//   Round-robin arbiter sharing one downstream naive_bus port among N_MASTER
//   upstream masters (index 0 = instruction fetch, 1 = data access).
//
//   The request path is purely combinational: the selected master's fields
//   reach the slave and the slave's grants reach only the selected master in
//   the same cycle. Read data returns one cycle after a read grant and is
//   steered to the master that owned that grant.
//
//   Parameters
//     N_MASTER   number of masters (2..4)
//   Ports
//     clk        rising-edge clock
//     rst_n      asynchronous active-low reset
//     masters    naive_bus.slave [N_MASTER] upstream requesters
//     slave      naive_bus.master           shared downstream port
//     o_rr_ptr   current round-robin priority pointer
// -----------------------------------------------------------------------------
module core_bus_arbiter
  import core_bus_arbiter_pkg::*;
#(
  parameter int unsigned N_MASTER = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  naive_bus.slave  masters [N_MASTER],
  naive_bus.master slave,
  output mst_idx_t o_rr_ptr
);

  bus_req_t              req_a [N_MASTER];
  logic [N_MASTER-1:0]   req_vec;
  logic [N_MASTER-1:0]   sel_oh;
  mst_idx_t              sel_idx;
  logic                  sel_vld;
  bus_req_t              fwd;

  mst_idx_t              rd_owner;
  logic                  rd_owner_vld;

  // Interface array elements need constant indices, so each master is
  // flattened into req_a[] here and all returns are driven per master.
  for (genvar i = 0; i < N_MASTER; i++) begin : g_mst
    assign req_a[i] = '{
      rd_req:  masters[i].rd_req,
      rd_be:   masters[i].rd_be,
      rd_addr: masters[i].rd_addr,
      wr_req:  masters[i].wr_req,
      wr_be:   masters[i].wr_be,
      wr_addr: masters[i].wr_addr,
      wr_data: masters[i].wr_data
    };
    assign req_vec[i] = masters[i].rd_req | masters[i].wr_req;

    assign masters[i].rd_gnt = slave.rd_gnt & sel_oh[i];
    assign masters[i].wr_gnt = slave.wr_gnt & sel_oh[i];

    // Read data belongs to whoever held the read grant last cycle; a fresh
    // grant to another master this cycle does not disturb the return.
    assign masters[i].rd_data =
      (rd_owner_vld && (rd_owner == mst_idx_t'(i))) ? slave.rd_data : '0;
  end

  rr_pick #(
    .N (N_MASTER)
  ) u_rr_pick (
    .req    (req_vec),
    .ptr    (o_rr_ptr),
    .gnt_oh (sel_oh),
    .idx    (sel_idx),
    .vld    (sel_vld)
  );

  // One-hot AND-OR style mux; all zero when nobody requests.
  always_comb begin
    fwd = '0;
    for (int unsigned i = 0; i < N_MASTER; i++) begin
      if (sel_oh[i]) begin
        fwd = req_a[i];
      end
    end
  end

  assign slave.rd_req  = fwd.rd_req;
  assign slave.rd_be   = fwd.rd_be;
  assign slave.rd_addr = fwd.rd_addr;
  assign slave.wr_req  = fwd.wr_req;
  assign slave.wr_be   = fwd.wr_be;
  assign slave.wr_addr = fwd.wr_addr;
  assign slave.wr_data = fwd.wr_data;

  // Pointer moves past the selected master only once it is actually served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_rr_ptr     <= '0;
      rd_owner     <= '0;
      rd_owner_vld <= 1'b0;
    end else begin
      if (sel_vld && (slave.rd_gnt || slave.wr_gnt)) begin
        o_rr_ptr <= wrap_inc(sel_idx, N_MASTER);
      end
      rd_owner_vld <= slave.rd_req & slave.rd_gnt;
      rd_owner     <= sel_idx;
    end
  end

endmodule : core_bus_arbiter
